// File: rtl/boot_ctrl.sv
// Boot loader: receives a length-prefixed, checksummed byte stream from a host, writes it into
// shared memory from address 0, then releases the processor and hands it the memory port.
module boot_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             host_valid,
   input  logic [7:0]       host_data,
   output logic             host_ready,
   input  logic             cpu_memread,
   input  logic             cpu_memwrite,
   input  logic [WIDTH-1:0] cpu_adr,
   input  logic [WIDTH-1:0] cpu_writedata,
   output logic             mem_read,
   output logic             mem_write,
   output logic [WIDTH-1:0] mem_adr,
   output logic [WIDTH-1:0] mem_writedata,
   output logic             cpu_reset,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LEN, LOAD, CSUM, RUN, ERR} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      sum_q, sum_d;
   logic [7:0]      len_q, len_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic            in_xfer;
   logic            accept;

   assign in_xfer    = (state_q == LEN) || (state_q == LOAD) || (state_q == CSUM);
   assign accept     = host_valid && in_xfer;
   assign host_ready = in_xfer;
   assign cpu_reset  = (state_q != RUN);
   assign busy       = in_xfer;
   assign done       = (state_q == RUN);
   assign err        = (state_q == ERR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      len_d   = len_q;
      case (state_q)
         IDLE: if (start) state_d = LEN;
         LEN: if (accept) begin
            len_d   = host_data;
            cnt_d   = 8'd0;
            sum_d   = 8'd0;
            state_d = (host_data == 8'd0) ? CSUM : LOAD;
         end
         LOAD: if (accept) begin
            cnt_d = cnt_q + 8'd1;
            sum_d = sum_q + host_data;
            if (cnt_q == len_q - 8'd1) state_d = CSUM;
         end
         CSUM: if (accept) state_d = (host_data == sum_q) ? RUN : ERR;
         RUN, ERR: if (start) state_d = LEN;
         default: state_d = IDLE;
      endcase
      // The edge that would carry the idle count to TIMEOUT lands directly in ERR.
      if (in_xfer && !accept && idle_q == IW'(TIMEOUT - 1)) state_d = ERR;

      if (!in_xfer || accept || state_d != state_q) idle_d = '0;
      else                                          idle_d = idle_q + 1'b1;
   end

   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_adr       = '0;
      mem_writedata = '0;
      if (state_q == RUN) begin
         mem_read      = cpu_memread;
         mem_write     = cpu_memwrite;
         mem_adr       = cpu_adr;
         mem_writedata = cpu_writedata;
      end else if (state_q == LOAD && accept) begin
         mem_write     = 1'b1;
         mem_adr       = WIDTH'(cnt_q);
         mem_writedata = WIDTH'(host_data);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         sum_q   <= 8'd0;
         len_q   <= 8'd0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         len_q   <= len_d;
         idle_q  <= idle_d;
      end
   end

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: inputs change on the falling edge, outputs are sampled mid low phase.
module tb_boot_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, host_valid, host_ready;
   logic [7:0] host_data;
   logic       cpu_memread, cpu_memwrite;
   logic [7:0] cpu_adr, cpu_writedata;
   logic       mem_read, mem_write;
   logic [7:0] mem_adr, mem_writedata;
   logic       cpu_reset, busy, done, err;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   boot_ctrl #(.WIDTH(8), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
      .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
      .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_adr(mem_adr), .mem_writedata(mem_writedata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_write === 1'b1) wr_count <= wr_count + 1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      host_valid = 1'b1;
      host_data  = b;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; host_valid = 1'b0; host_data = 8'h00;
      cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_adr = 8'h00; cpu_writedata = 8'h00;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      cpu_memread = 1'b1; cpu_memwrite = 1'b1; cpu_adr = 8'h12;
      #1;
      if ({cpu_reset, host_ready, mem_read, mem_write, busy, done, err} !== 7'b1000000) begin
         errors++; $display("FAIL reset_outputs got %b exp 1000000",
                            {cpu_reset, host_ready, mem_read, mem_write, busy, done, err});
      end
      checks++;
      cpu_memread = 1'b0; cpu_memwrite = 1'b0;
      drive_byte(8'h55);
      tick();
      host_valid = 1'b0;
      if (busy !== 1'b0 || host_ready !== 1'b0) begin
         errors++; $display("FAIL idle_ignores_valid got busy=%b ready=%b exp 0 0", busy, host_ready);
      end
      checks++;
   endtask

   task automatic test_basic_load();
      logic [7:0] data [3];
      int wr0;
      data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
      do_reset();
      wr0 = wr_count;
      pulse_start();
      if (busy !== 1'b1 || host_ready !== 1'b1 || cpu_reset !== 1'b1) begin
         errors++; $display("FAIL len_state got busy=%b ready=%b cpu_reset=%b exp 1 1 1",
                            busy, host_ready, cpu_reset);
      end
      checks++;
      drive_byte(8'h03);
      if (mem_write !== 1'b0) begin
         errors++; $display("FAIL len_no_write got %b exp 0", mem_write);
      end
      checks++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive_byte(data[i]);
         if (mem_write !== 1'b1 || mem_adr !== 8'(i) || mem_writedata !== data[i]) begin
            errors++; $display("FAIL load_write%0d got we=%b adr=%h dat=%h exp 1 %h %h",
                               i, mem_write, mem_adr, mem_writedata, 8'(i), data[i]);
         end
         checks++;
         tick();
      end
      drive_byte(8'h66);
      if (mem_write !== 1'b0 || cpu_reset !== 1'b1) begin
         errors++; $display("FAIL csum_cycle got we=%b cpu_reset=%b exp 0 1", mem_write, cpu_reset);
      end
      checks++;
      tick();
      host_valid = 1'b0;
      if (cpu_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || host_ready !== 1'b0) begin
         errors++; $display("FAIL run_entry got cpu_reset=%b done=%b busy=%b ready=%b exp 0 1 0 0",
                            cpu_reset, done, busy, host_ready);
      end
      checks++;
      if (wr_count - wr0 !== 3) begin
         errors++; $display("FAIL basic_write_count got %0d exp 3", wr_count - wr0);
      end
      checks++;
      cpu_memread = 1'b1; cpu_memwrite = 1'b1; cpu_adr = 8'h5A; cpu_writedata = 8'hC3;
      #1;
      if (mem_read !== 1'b1 || mem_write !== 1'b1 || mem_adr !== 8'h5A || mem_writedata !== 8'hC3) begin
         errors++; $display("FAIL run_passthru got rd=%b we=%b adr=%h dat=%h exp 1 1 5a c3",
                            mem_read, mem_write, mem_adr, mem_writedata);
      end
      checks++;
      cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_adr = 8'h00; cpu_writedata = 8'h00;
   endtask

   task automatic test_bad_checksum();
      do_reset();
      pulse_start();
      drive_byte(8'h02); tick();
      drive_byte(8'h0A); tick();
      drive_byte(8'h0B); tick();
      drive_byte(8'h00); tick();
      host_valid = 1'b0;
      if (err !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL bad_csum got err=%b done=%b cpu_reset=%b busy=%b exp 1 0 1 0",
                            err, done, cpu_reset, busy);
      end
      checks++;
      cpu_memread = 1'b1; cpu_memwrite = 1'b1; cpu_adr = 8'h40; cpu_writedata = 8'hEE;
      #1;
      if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
         errors++; $display("FAIL err_blocks_cpu got we=%b rd=%b exp 0 0", mem_write, mem_read);
      end
      checks++;
      cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_adr = 8'h00; cpu_writedata = 8'h00;
   endtask

   task automatic test_wrap_zero();
      int wr0;
      do_reset();
      pulse_start();
      drive_byte(8'h02); tick();
      drive_byte(8'hFF); tick();
      drive_byte(8'h02); tick();
      drive_byte(8'h01); tick();
      host_valid = 1'b0;
      if (done !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL sum_wrap got done=%b err=%b exp 1 0", done, err);
      end
      checks++;
      do_reset();
      wr0 = wr_count;
      pulse_start();
      drive_byte(8'h00); tick();
      drive_byte(8'h00); tick();
      host_valid = 1'b0;
      if (done !== 1'b1 || wr_count - wr0 !== 0) begin
         errors++; $display("FAIL zero_len got done=%b writes=%0d exp 1 0", done, wr_count - wr0);
      end
      checks++;
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_start();
      drive_byte(8'h02); tick();
      drive_byte(8'hAA); tick();
      host_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_wait%0d got busy=%b err=%b exp 1 0", i, busy, err);
         end
         checks++;
      end
      tick();
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout_err got err=%b busy=%b exp 1 0", err, busy);
      end
      checks++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      pulse_start();
      drive_byte(8'h03); tick();
      drive_byte(8'h11); tick();
      drive_byte(8'h22); tick();
      host_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if ({cpu_reset, host_ready, busy, done, err} !== 5'b10000) begin
         errors++; $display("FAIL mid_reset_idle got %b exp 10000",
                            {cpu_reset, host_ready, busy, done, err});
      end
      checks++;
      pulse_start();
      drive_byte(8'h02); tick();
      drive_byte(8'h44);
      if (mem_write !== 1'b1 || mem_adr !== 8'h00) begin
         errors++; $display("FAIL reload_first_adr got we=%b adr=%h exp 1 00", mem_write, mem_adr);
      end
      checks++;
      tick();
      drive_byte(8'h55); tick();
      drive_byte(8'h99); tick();
      host_valid = 1'b0;
      if (done !== 1'b1 || cpu_reset !== 1'b0) begin
         errors++; $display("FAIL after_reset_load got done=%b cpu_reset=%b exp 1 0", done, cpu_reset);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      // Entered in RUN from the previous scenario.
      pulse_start();
      if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL run_restart got cpu_reset=%b done=%b busy=%b exp 1 0 1",
                            cpu_reset, done, busy);
      end
      checks++;
      drive_byte(8'h02); tick();
      drive_byte(8'h7E);
      if (mem_write !== 1'b1 || mem_adr !== 8'h00 || mem_writedata !== 8'h7E) begin
         errors++; $display("FAIL restart_adr0 got we=%b adr=%h dat=%h exp 1 00 7e",
                            mem_write, mem_adr, mem_writedata);
      end
      checks++;
      tick();
      start = 1'b1;
      drive_byte(8'h01);
      if (mem_write !== 1'b1 || mem_adr !== 8'h01) begin
         errors++; $display("FAIL start_ignored_load got we=%b adr=%h exp 1 01", mem_write, mem_adr);
      end
      checks++;
      tick();
      start = 1'b0;
      drive_byte(8'h7F); tick();
      host_valid = 1'b0;
      if (done !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL restart_done got done=%b err=%b exp 1 0", done, err);
      end
      checks++;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; host_valid = 1'b0; host_data = 8'h00;
      cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_adr = 8'h00; cpu_writedata = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic_load();
      test_bad_checksum();
      test_wrap_zero();
      test_timeout();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: memory address/data width, equal to the processor WIDTH.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum idle cycles allowed between accepted host bytes.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 SHALL have ports host_valid (input, 1 bit), host_data (input, 8 bits) and host_ready (output, 1 bit): byte-stream handshake; a byte transfers when valid&ready are high at a rising edge.
REQ-007 SHALL have ports cpu_memread and cpu_memwrite (inputs, 1 bit each), and cpu_adr and cpu_writedata (inputs, WIDTH each): the processor memory request.
REQ-008 SHALL have ports mem_read and mem_write (outputs, 1 bit each), and mem_adr and mem_writedata (outputs, WIDTH each): the shared memory port.
REQ-009 SHALL have port cpu_reset, output, 1 bit: drives the processor's synchronous reset.
REQ-010 SHALL have ports busy, done and err (outputs, 1 bit each): status flags.

Function
REQ-011 SHALL implement states IDLE, LEN, LOAD, CSUM, RUN and ERR.
REQ-012 SHALL, in IDLE, move to LEN on start=1.
REQ-013 SHALL, in LEN, capture the accepted byte as N and clear cnt and sum; N=0 -> CSUM, otherwise -> LOAD.
REQ-014 SHALL, in LOAD, drive each accepted byte combinationally in the same cycle: mem_write=1, mem_adr=cnt (zero-extended), mem_writedata=host_data (zero-extended).
REQ-015 SHALL, in LOAD, on each accepted byte do cnt+=1 and sum=(sum+byte) mod 256; the byte accepted with cnt=N-1 -> CSUM.
REQ-016 SHALL, in CSUM, compare the accepted byte with sum: equal -> RUN, unequal -> ERR.
REQ-017 SHALL drive host_ready=1 only in LEN, LOAD and CSUM; it is a combinational function of state, so every offered byte is accepted without stalls.
REQ-018 SHALL run an idle counter in LEN, LOAD and CSUM that clears on every accepted byte and on state entry, and otherwise increments; if it reaches TIMEOUT with no byte accepted, the next state SHALL be ERR.
REQ-019 SHALL, in RUN, pass cpu_memread, cpu_memwrite, cpu_adr and cpu_writedata straight to the mem_* outputs (combinational, zero latency).
REQ-020 SHALL, in all states except RUN, force mem_read=0 and ignore the cpu_* inputs; mem_write is asserted only per REQ-014.
REQ-021 SHALL drive cpu_reset=1 in every state except RUN, so the processor starts FETCH1 at the first edge after RUN is entered.
REQ-022 SHALL drive busy=1 in LEN/LOAD/CSUM, done=1 in RUN and err=1 in ERR; all are decoded from state.
REQ-023 SHALL, on start=1 in RUN or ERR, go to LEN: reassert cpu_reset and clear done/err that cycle; start is ignored in LEN/LOAD/CSUM.
REQ-024 SHALL treat host_valid as don't-care outside LEN/LOAD/CSUM; no byte is consumed.
REQ-025 SHALL hold sum as 8 bits with wrap-around, cnt as 8 bits, and the idle counter wide enough for TIMEOUT.

Reset
REQ-026 SHALL, on reset=1 at any edge (including mid-load), enter IDLE and clear cnt, sum, N and the idle counter; at reset the outputs are cpu_reset=1, host_ready=0, mem_read=0, mem_write=0, busy=0, done=0, err=0.
REQ-027 SHALL NOT undo memory bytes already written when reset interrupts a load.

Verification
REQ-028 Basic load: start, then bytes 03,11,22,33,66 -> writes 11@0, 22@1, 33@2; RUN; cpu_reset low one cycle after the checksum byte; done=1.
REQ-029 Bad checksum: 02,0A,0B,00 -> ERR, err=1, cpu_reset stays 1, and cpu_memwrite is not propagated to mem_write.
REQ-030 Wrap and zero length: 02,FF,02,01 -> RUN (sum wraps to 01); separately 00,00 -> RUN with no memory writes.
REQ-031 Timeout: TIMEOUT=4, send 02,AA, then hold host_valid=0 -> ERR exactly 4 cycles after the AA handshake.
REQ-032 Mid-load reset: reset asserted after the second data byte -> IDLE next edge, then a fresh start and a full load succeed.
REQ-033 Reload from RUN: start in RUN -> cpu_reset=1 and done=0 in the next cycle; a new load then writes from address 0.
